// File: rtl/rom_access_scheduler.sv
// rom_access_scheduler
//
// Shares one asynchronous EPROM/PROM device between NUM_REQ requesters. In
// idle, a round-robin arbiter picks one pending request, the device address
// is registered, and CE/OE are held low for ACCESS_CYCLES clocks. Read data
// is then sampled into rdata, CE/OE are released, and the device is left idle
// for HOLD_CYCLES clocks before the next request can be accepted.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester level-sensitive read request
//   req_addr   flattened per-requester addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   gnt        one-hot single-cycle pulse: address captured
//   rvalid     one-hot single-cycle pulse: rdata valid for that requester
//   rdata      registered read data, held until the next rvalid
//   busy       high whenever the scheduler is not idle
//   mem_ce_n   device chip enable, active low
//   mem_oe_n   device output enable, active low
//   mem_addr   registered device address
//   mem_data   device data bus
//
// ACCESS_CYCLES must be in 1..255 and HOLD_CYCLES in 0..15.

module rom_access_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ACCESS_CYCLES = 10,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic                          mem_ce_n,
  output logic                          mem_oe_n,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_data
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [7:0]      AccessLoad = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0]      HoldLoad   = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;
  // Pointer starts at the last requester so requester 0 wins first after reset.
  localparam logic [IdxW-1:0] LastInit   = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRecover
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [IdxW-1:0]         last_q, last_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      rvalid_q, rvalid_d;
  logic                    ce_n_q, ce_n_d;

  // Unpacked view of the flattened address bus.
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_addr
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Round-robin search starting just after the last winner, wrapping at NUM_REQ.
  logic            found;
  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    ce_n_d     = ce_n_q;
    gnt_d      = '0;
    rvalid_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d     = StAccess;
          mem_addr_d  = addr_arr[pick];
          ce_n_d      = 1'b0;
          gnt_d[pick] = 1'b1;
          last_d      = pick;
          cnt_d       = AccessLoad;
        end
      end

      StAccess: begin
        if (cnt_q == 8'd0) begin
          rdata_d          = mem_data;
          // last_q already holds the winner of the current access.
          rvalid_d[last_q] = 1'b1;
          ce_n_d           = 1'b1;
          if (HOLD_CYCLES == 0) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end else begin
            state_d = StRecover;
            cnt_d   = HoldLoad;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StRecover: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
        ce_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      last_q     <= LastInit;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      ce_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      ce_n_q     <= ce_n_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_ce_n = ce_n_q;
  // OE follows CE: the device is only ever read.
  assign mem_oe_n = ce_n_q;
  assign busy     = (state_q != StIdle);

endmodule
